// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uarttx transmitter between NUM_REQ clients.
// Holds send until a synchronised donetx rise, or until the watchdog aborts the transfer.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 2048
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        timeout_err,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        uart_send,
  output logic [DATA_W-1:0]           uart_dintx,
  input  logic                        uart_donetx
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_n;
  logic                s1, s2, s3;
  logic                done_rise;
  logic [ID_W-1:0]     ptr_q, ptr_n;
  logic [TMR_W-1:0]    timer_q, timer_n;
  logic [ID_W-1:0]     grant_n;
  logic [ID_W-1:0]     next_ptr;
  logic [DATA_W-1:0]   data_n;
  logic                send_n;
  logic [NUM_REQ-1:0]  ack_n;
  logic                tmo_n;
  logic                busy_n;
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  int unsigned         idx;
  logic [DATA_W-1:0]   req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  // donetx crosses from the uclk domain: two-flop sync plus an edge-detect flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= uart_donetx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign done_rise = s2 & ~s3;

  // First pending request at or after the round-robin pointer
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[ID_W'(idx)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_comb begin
    state_n = state_q;
    send_n  = 1'b0;
    ack_n   = '0;
    tmo_n   = 1'b0;
    grant_n = grant_id;
    data_n  = uart_dintx;
    ptr_n   = ptr_q;
    timer_n = timer_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_n = win_id;
          data_n  = req_bytes[win_id];
          send_n  = 1'b1;
          timer_n = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        send_n  = 1'b1;
        timer_n = timer_q + TMR_W'(1);
        // A done arriving on the watchdog's last cycle wins over the abort
        if (done_rise) begin
          send_n          = 1'b0;
          ack_n[grant_id] = 1'b1;
          ptr_n           = next_ptr;
          state_n         = RELEASE;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          send_n          = 1'b0;
          ack_n[grant_id] = 1'b1;
          tmo_n           = 1'b1;
          ptr_n           = next_ptr;
          state_n         = RELEASE;
        end
      end
      RELEASE: begin
        if (!s2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      timer_q     <= '0;
      grant_id    <= '0;
      uart_dintx  <= '0;
      uart_send   <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ptr_q       <= ptr_n;
      timer_q     <= timer_n;
      grant_id    <= grant_n;
      uart_dintx  <= data_n;
      uart_send   <= send_n;
      ack         <= ack_n;
      timeout_err <= tmo_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: plays the uarttx donetx handshake and checks grants, acks,
// watchdog aborts and reset behaviour against hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned TIMEOUT_CYC = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        timeout_err;
  logic        busy;
  logic [1:0]  grant_id;
  logic        uart_send;
  logic [7:0]  uart_dintx;
  logic        uart_donetx;

  int vectors     = 0;
  int miscompares = 0;
  int ack_cnt     = 0;
  int multi_ack   = 0;
  logic [7:0] bytes [4];

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .timeout_err(timeout_err), .busy(busy), .grant_id(grant_id),
    .uart_send(uart_send), .uart_dintx(uart_dintx), .uart_donetx(uart_donetx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (|ack) ack_cnt++;
    if ($countones(ack) > 1) multi_ack++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_bytes();
    for (int i = 0; i < 4; i++) req_data[8*i +: 8] = bytes[i];
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("rst_send", 32'(uart_send), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_grant", 32'(grant_id), 32'd0);
    check_eq("rst_dintx", 32'(uart_dintx), 32'd0);
    check_eq("rst_tmo", 32'(timeout_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One transfer: wait for send, check the grant, then answer with donetx after dly cycles
  // (dly < 0: never answer and expect the watchdog abort).
  task automatic xfer(input int exp_id, input int dly, input bit drop_req);
    int n;
    logic [3:0] exp_ack;
    exp_ack = 4'(1 << exp_id);
    n = 0;
    while (!uart_send && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("send_rise", 32'(uart_send), 32'd1);
    if (!uart_send) return;
    check_eq("grant_id", 32'(grant_id), 32'(exp_id));
    check_eq("dintx", 32'(uart_dintx), 32'(bytes[exp_id]));
    check_eq("busy_send", 32'(busy), 32'd1);
    if (drop_req) req = '0;
    if (dly < 0) begin
      repeat (TIMEOUT_CYC - 1) @(posedge clk);
      #1;
      check_eq("pre_tmo_send", 32'(uart_send), 32'd1);
      check_eq("pre_tmo_ack", 32'(ack), 32'd0);
      @(posedge clk); #1;
      check_eq("tmo_ack", 32'(ack), 32'(exp_ack));
      check_eq("tmo_err", 32'(timeout_err), 32'd1);
      check_eq("tmo_send", 32'(uart_send), 32'd0);
    end else begin
      repeat (dly) @(posedge clk);
      #1 uart_donetx = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("pre_ack", 32'(ack), 32'd0);
      check_eq("pre_ack_send", 32'(uart_send), 32'd1);
      @(posedge clk); #1;
      check_eq("ack", 32'(ack), 32'(exp_ack));
      check_eq("done_no_tmo", 32'(timeout_err), 32'd0);
      check_eq("done_send", 32'(uart_send), 32'd0);
      uart_donetx = 1'b0;
    end
    @(posedge clk); #1;
    check_eq("ack_pulse", 32'(ack), 32'd0);
    check_eq("tmo_pulse", 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int acks_before;
    rst = 1'b0;
    req = '0;
    uart_donetx = 1'b0;
    for (int i = 0; i < 4; i++) bytes[i] = 8'h00;
    set_bytes();
    #1;
    check_eq("por_send", 32'(uart_send), 32'd0);
    check_eq("por_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // single request, dropped mid-transfer but still acked
    bytes[2] = 8'hA5;
    set_bytes();
    req = 4'b0100;
    xfer(2, 4, 1'b1);

    // all four requesting: strict rotation from a fresh pointer
    do_reset();
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    set_bytes();
    req = 4'b1111;
    xfer(0, 3, 1'b0);
    xfer(1, 7, 1'b0);
    xfer(2, 0, 1'b0);
    xfer(3, 5, 1'b0);
    xfer(0, 2, 1'b0);
    req = '0;

    // pointer sits past requester 1, so 3 beats 0
    req = 4'b0010;
    xfer(1, 2, 1'b1);
    req = 4'b1001;
    xfer(3, 2, 1'b0);
    xfer(0, 2, 1'b1);

    // watchdog abort on requester 1, then requester 2 served normally
    req = 4'b0110;
    xfer(1, -1, 1'b0);
    req = 4'b0100;
    xfer(2, 6, 1'b1);

    // done lands on the watchdog's last cycle: normal completion
    req = 4'b1000;
    xfer(3, TIMEOUT_CYC - 3, 1'b1);
    repeat (4) @(posedge clk);
    #1 check_eq("idle_busy", 32'(busy), 32'd0);

    // reset in the middle of SEND
    req = 4'b0001;
    @(posedge clk); #1;
    check_eq("mid_send", 32'(uart_send), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_send", 32'(uart_send), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ack", 32'(ack), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    req = 4'b1010;
    rst = 1'b1;
    xfer(1, 4, 1'b1);

    // two clients, bytes 0x55 and 0xC3 in requester order
    do_reset();
    bytes[0] = 8'h55; bytes[2] = 8'hC3;
    set_bytes();
    acks_before = ack_cnt;
    req = 4'b0101;
    xfer(0, 10, 1'b0);
    req = 4'b0100;
    xfer(2, 10, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check_eq("two_acks", 32'(ack_cnt - acks_before), 32'd2);
    check_eq("onehot_ack", 32'(multi_ack), 32'd0);
    check_eq("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
